first_nns_seq: RTL

Sequential, streaming counterpart of the combinational first-nearest-neighbour search in the knns circuit set. It latches one query word, then accepts N database entries one per cycle over a valid/ready handshake. It returns the entry with minimum Hamming distance to the query, together with its index and distance; on ties the earliest entry wins. It sits between a database feeder (memory or garbled-input streamer) and downstream k-NN logic, trading N parallel popcounts for one popcount and a counter.

---
 rtl/first_nns_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/first_nns_seq.sv
// Streaming first-nearest-neighbour search: one query, N entries per search.
// Returns the earliest entry with minimum Hamming distance, its index and distance.
module first_nns_seq #(
    parameter int W = 15,
    parameter int N = 32,
    localparam int LOGW = $clog2(W + 1),
    localparam int LOGN = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    g_input,
    input  logic            e_valid,
    input  logic [W-1:0]    e_input,
    output logic            e_ready,
    output logic [W-1:0]    o,
    output logic [LOGN-1:0] o_idx,
    output logic [LOGW-1:0] o_dist,
    output logic            o_valid,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [W-1:0]    q;
    logic [W-1:0]    best_val;
    logic [LOGW-1:0] best_dist;
    logic [LOGN-1:0] best_idx;
    logic [LOGN-1:0] cnt;
    logic [W-1:0]    diff;
    logic [LOGW-1:0] d;
    logic            accept;
    logic            last;

    assign diff   = q ^ e_input;
    assign accept = e_valid && (state == SCAN);
    assign last   = (cnt == LOGN'(N - 1));

    // Single shared popcount; W always fits in LOGW bits
    always_comb begin
        d = '0;
        for (int i = 0; i < W; i++) begin
            d = d + LOGW'(diff[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        e_ready  = 1'b0;
        busy     = 1'b0;
        o_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                e_ready = 1'b1;
                busy    = 1'b1;
                if (accept && last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                o_valid  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= '0;
            cnt       <= '0;
            best_val  <= '0;
            best_dist <= '0;
            best_idx  <= '0;
        end else begin
            if (state == IDLE && start) begin
                q   <= g_input;
                cnt <= '0;
            end
            if (accept) begin
                // Strict compare keeps the earliest minimum on ties
                if (cnt == '0 || d < best_dist) begin
                    best_val  <= e_input;
                    best_dist <= d;
                    best_idx  <= cnt;
                end
                if (!last) begin
                    cnt <= cnt + LOGN'(1);
                end
            end
        end
    end

    assign o      = best_val;
    assign o_idx  = best_idx;
    assign o_dist = best_dist;

endmodule
